cache_array_arb: RTL
====================

CACHE_ARRAY_ARB -- requirements
Module: cache_array_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one cache data-array port (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, array index width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, array data width.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, with ports:
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  asynchronous active-low reset
REQ-005 SHALL have these requester-side ports:
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_ready_o  out  NUM_REQ  per-requester accept
- req_we_i  in  NUM_REQ  1 = write, 0 = read
- req_last_i  in  NUM_REQ  1 = final beat of burst; 0 = keep grant locked
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at slice i
- req_wdata_i  in  NUM_REQ*DATA_WIDTH  packed write data
- resp_valid_o  out  NUM_REQ  one-hot read-data valid
- resp_rdata_o  out  DATA_WIDTH  read data, shared
REQ-006 SHALL have these array-side ports:
- arr_en_o  out  1  array access enable
- arr_we_o  out  1  array write enable
- arr_addr_o  out  ADDR_WIDTH  array index
- arr_wdata_o  out  DATA_WIDTH  array write data
- arr_rdata_i  in  DATA_WIDTH  array read data, valid one cycle after a read access

Function
REQ-007 SHALL hold a round-robin pointer ptr (0..NUM_REQ-1) and a lock state: IDLE or LOCKED(owner).
REQ-008 In IDLE, SHALL grant the first asserted req_valid_i searching ptr, ptr+1, ... wrapping modulo NUM_REQ.
REQ-009 In LOCKED, SHALL grant only owner; other requesters SHALL see req_ready_o=0.
REQ-010 req_ready_o SHALL be combinational, one-hot or zero, asserted only for the granted requester with req_valid_i=1; a handshake is valid&ready in the same cycle.
REQ-011 On handshake with req_last_i=0: SHALL enter or stay in LOCKED(grantee); ptr SHALL be unchanged.
REQ-012 On handshake with req_last_i=1: SHALL go to IDLE and set ptr = (grantee+1) mod NUM_REQ.
REQ-013 In LOCKED with owner valid deasserted: SHALL stay LOCKED, issue nothing, and not time out.
REQ-014 Array command SHALL be registered: a handshake in cycle T drives arr_en_o=1, arr_we_o=req_we_i, and arr_addr_o/arr_wdata_o from the grantee in cycle T+1; with no handshake, arr_en_o=0 and arr_we_o=0 in T+1.
REQ-015 A read handshake in cycle T SHALL assert resp_valid_o[grantee] in cycle T+2 for exactly one cycle, with resp_rdata_o=arr_rdata_i; writes SHALL produce no response.
REQ-016 Back-to-back handshakes SHALL sustain one access per cycle; responses return in issue order.
REQ-017 resp_rdata_o SHALL be arr_rdata_i passed through, or zero when no resp_valid_o bit is set; either is compliant, and benches SHALL check it only when valid.
REQ-018 With no req_valid_i asserted in IDLE, ptr and state SHALL hold.

Reset
REQ-019 While rstn=0: ptr=0; state IDLE; arr_en_o=0; arr_we_o=0; arr_addr_o=0; arr_wdata_o=0; resp_valid_o=0; in-flight read tracking cleared; req_ready_o=0.
REQ-020 Reset asserted mid-burst or with a read in flight SHALL drop the lock and the pending response; no resp_valid_o after rstn deasserts.
REQ-021 The first grant after reset SHALL use the search order 0,1,2,...

Verification
REQ-022 After reset, requesters 0 and 2 valid, read, last=1, each held until granted -> grant 0 at T0, arr_en_o at T0+1, resp_valid_o=0001 at T0+2; grant 2 at T0+1; ptr=3.
REQ-023 All four valid and continuously re-requesting with last=1 -> grant order 0,1,2,3,0, one handshake per cycle.
REQ-024 Requester 1 sends a 4-beat write burst (last=0,0,0,1) while 0 and 3 stay valid -> four consecutive grants to 1, arr_we_o=1 for four cycles, then grant 3, then 0.
REQ-025 Owner 1 drops valid for 3 cycles mid-burst while 2 valid -> req_ready_o=0000 and arr_en_o=0 during the gap; grant resumes to 1.
REQ-026 rstn pulsed low one cycle after a read handshake -> no resp_valid_o; state IDLE, ptr=0.
REQ-027 Write 0xDEAD_BEEF to addr 5 by requester 3, then read addr 5 by requester 0 -> array model returns 0xDEAD_BEEF with resp_valid_o=0001.

Source files
------------

// File: rtl/cache_array_arb.sv
// ---------------------------------------------------------------------------
// cache_array_arb
//   Round-robin arbiter that lets NUM_REQ requesters share one single-port
//   cache data array. A requester may hold the grant across a multi-beat
//   burst by keeping req_last_i low. Array commands are registered. Read data
//   comes back to the issuing requester two cycles after its handshake.
//
// Ports
//   clk, rstn        : clock (rising edge), asynchronous active-low reset
//   req_valid_i      : per-requester request valid
//   req_ready_o      : per-requester accept (combinational, one-hot or zero)
//   req_we_i         : per-requester write (1) / read (0)
//   req_last_i       : per-requester final beat of burst (0 keeps the lock)
//   req_addr_i       : packed addresses, requester i at slice i
//   req_wdata_i      : packed write data, requester i at slice i
//   resp_valid_o     : one-hot read response valid
//   resp_rdata_o     : shared read data (zero when no response is valid)
//   arr_en_o         : array access enable
//   arr_we_o         : array write enable
//   arr_addr_o       : array index
//   arr_wdata_o      : array write data
//   arr_rdata_i      : array read data, valid one cycle after a read access
// ---------------------------------------------------------------------------
module cache_array_arb #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 64
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [NUM_REQ-1:0]               req_valid_i,
    output logic [NUM_REQ-1:0]               req_ready_o,
    input  logic [NUM_REQ-1:0]               req_we_i,
    input  logic [NUM_REQ-1:0]               req_last_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata_i,
    output logic [NUM_REQ-1:0]               resp_valid_o,
    output logic [DATA_WIDTH-1:0]            resp_rdata_o,
    output logic                             arr_en_o,
    output logic                             arr_we_o,
    output logic [ADDR_WIDTH-1:0]            arr_addr_o,
    output logic [DATA_WIDTH-1:0]            arr_wdata_o,
    input  logic [DATA_WIDTH-1:0]            arr_rdata_i
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t                  r_state;
    logic [PTR_W-1:0]        r_ptr;
    logic [PTR_W-1:0]        r_owner;

    logic                    r_arr_en;
    logic                    r_arr_we;
    logic [ADDR_WIDTH-1:0]   r_arr_addr;
    logic [DATA_WIDTH-1:0]   r_arr_wdata;

    logic                    r_rd_pend;
    logic [PTR_W-1:0]        r_rd_owner;
    logic [NUM_REQ-1:0]      r_resp_valid;

    logic                    w_hs;
    logic [PTR_W-1:0]        w_gnt;
    logic [PTR_W-1:0]        w_ptr_next;
    logic                    w_sel_we;
    logic                    w_sel_last;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_wdata;

    // Grant selection. The idle search runs from the farthest offset down to
    // offset zero so the nearest valid requester (starting at r_ptr) wins.
    // Grants are suppressed while reset is asserted.
    always_comb begin
        w_hs  = 1'b0;
        w_gnt = r_ptr;
        if (r_state == ST_LOCKED) begin
            w_gnt = r_owner;
            w_hs  = req_valid_i[r_owner];
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (req_valid_i[PTR_W'((int'(r_ptr) + k) % NUM_REQ)]) begin
                    w_hs  = 1'b1;
                    w_gnt = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
                end
            end
        end
        w_hs = w_hs & rstn;
    end

    // Pick out the granted requester's command fields.
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt == PTR_W'(i)) begin
                w_sel_we    = req_we_i[i];
                w_sel_last  = req_last_i[i];
                w_sel_addr  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_ptr_next = (w_gnt == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;

    always_comb begin
        req_ready_o = '0;
        if (w_hs) begin
            req_ready_o[w_gnt] = 1'b1;
        end
    end

    // Lock state and round-robin pointer. The pointer only advances when a
    // burst finishes, so a locked owner never loses its turn.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
        end else if (w_hs) begin
            if (w_sel_last) begin
                r_state <= ST_IDLE;
                r_ptr   <= w_ptr_next;
            end else begin
                r_state <= ST_LOCKED;
                r_owner <= w_gnt;
            end
        end
    end

    // Registered array command plus the two-stage read tracker: stage one
    // marks the cycle the array sees the read, stage two is when its data
    // is on arr_rdata_i.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_arr_en     <= 1'b0;
            r_arr_we     <= 1'b0;
            r_arr_addr   <= '0;
            r_arr_wdata  <= '0;
            r_rd_pend    <= 1'b0;
            r_rd_owner   <= '0;
            r_resp_valid <= '0;
        end else begin
            r_arr_en  <= w_hs;
            r_arr_we  <= w_hs & w_sel_we;
            r_rd_pend <= w_hs & ~w_sel_we;
            if (w_hs) begin
                r_arr_addr  <= w_sel_addr;
                r_arr_wdata <= w_sel_wdata;
                r_rd_owner  <= w_gnt;
            end
            r_resp_valid <= '0;
            if (r_rd_pend) begin
                r_resp_valid[r_rd_owner] <= 1'b1;
            end
        end
    end

    assign arr_en_o     = r_arr_en;
    assign arr_we_o     = r_arr_we;
    assign arr_addr_o   = r_arr_addr;
    assign arr_wdata_o  = r_arr_wdata;
    assign resp_valid_o = r_resp_valid;
    assign resp_rdata_o = (|r_resp_valid) ? arr_rdata_i : '0;

endmodule
